instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit feeding the instruction register/decoder. Owns the fetch PC, issues word requests to instruction memory over a req/ready handshake, and hands each returned word to the decoder as `mem_data` with a one-cycle `load_instr` strobe. Consumes the decoder's control-flow outputs (`jmp`, `jal`, `jreg`, `breq`, `brne`, `exception`, `halt`, `addr`, `imm`) to redirect the PC. Produces the link value for JAL and the exception PC.

## Interface
- BITS, 32, data/address word width
- JMP_LEFT, 25, left bit of jump target field
- IMM_LEFT, 16, immediate field width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- EXC_VECTOR, 32'h0000_0080, exception target

Ports:
- clk  in  1  system clock
- rst_  in  1  reset: asynchronous, active-low
- imem_req  out  1  instruction memory request
- imem_addr  out  BITS  request word address (byte address, [1:0]=0)
- imem_ready  in  1  memory returns data this cycle
- imem_rdata  in  BITS  returned instruction
- mem_data  out  BITS  instruction to decoder (= imem_rdata)
- load_instr  out  1  decoder load strobe
- jmp, jal, jreg, breq, brne, exception, halt  in  1 each  decoder controls
- equal, not_equal  in  1  branch compare results
- addr  in  JMP_LEFT+1  jump target field
- imm  in  IMM_LEFT  branch offset field
- jreg_data  in  BITS  register value for JR
- pc  out  BITS  current fetch PC
- link_pc  out  BITS  dec_pc+4, JAL return address
- epc  out  BITS  PC of instruction that raised exception

## Operation
- Registers: fetch_pc, dec_pc (PC of word currently in decoder), dec_valid, redir_done, discard, pend_pc, epc, state.
- States: IDLE (reset), FETCH, HALTED.
- IDLE -> FETCH on first clk after reset release. HALTED exits only by reset.
- FETCH: imem_req=1, imem_addr=fetch_pc. Handshake: once asserted, req and addr held stable until imem_ready.
- Accept (imem_req & imem_ready): if no discard and no redirect this cycle -> load_instr=1, dec_pc<=fetch_pc, dec_valid<=1, redir_done<=0, fetch_pc<=fetch_pc+4.
- Redirect condition (only when dec_valid & !redir_done), priority high->low:
  - exception: target EXC_VECTOR, epc<=dec_pc
  - jreg: target jreg_data
  - jmp or jal: target {link_pc[31:28], addr, 2'b00}
  - (breq & equal) | (brne & not_equal): target link_pc + (sign_ext(imm) << 2), modulo 2^BITS
- On redirect: redir_done<=1 (one redirect per decoded instruction; JAL, which the decoder does not flush, must not re-fire).
  - No request outstanding or imem_ready same cycle: fetch_pc<=target, returned word (if any) dropped, load_instr=0.
  - Request outstanding, not ready: pend_pc<=target, discard<=1; on ready the word is dropped, fetch_pc<=pend_pc, discard<=0.
- halt (dec_valid): if no request outstanding -> HALTED next cycle; else complete the pending handshake, drop its data, then HALTED. halt outranks redirects. HALTED: imem_req=0, load_instr=0.
- Decoder holds NOP after reset; redirects ignored while dec_valid=0.

## Timing
- Reset values: imem_req 0, imem_addr/pc RESET_PC, load_instr 0, dec_pc RESET_PC, link_pc RESET_PC+4, epc 0, dec_valid 0, redir_done 0, discard 0.
- First imem_req=1 one cycle after rst_ rises.
- load_instr combinational from imem_ready in FETCH; mem_data = imem_rdata; decoder latches at that edge.
- Zero-wait memory: one instruction per cycle; taken redirect costs one dropped word (two cycles target-to-decode).
- Redirect and ready in same cycle: redirect wins, word dropped.
- Reset mid-transaction: req drops immediately; all state to reset values; late imem_ready ignored.

## Test plan
- Zero-wait sequential: ready held 1 after reset -> imem_addr 0,4,8,C on consecutive cycles, load_instr 1 each, link_pc tracks dec_pc+4.
- Wait states: ready low 2 cycles per word -> addr stable while waiting, load_instr only on ready, pc advances by 4 per accept.
- BEQ taken: dec_pc=0x10, imm=16'hFFFC, breq=equal=1 -> next fetch 0x04, in-flight word dropped, redirect fires once.
- JAL held in decoder: dec_pc=0x20, addr=26'h40, jal=jmp=1 for 2 cycles -> single redirect to 0x100, link_pc=0x24.
- Redirect during pending request: ready low, jreg_data=0x200, jreg=1 -> old word dropped on ready, next req addr 0x200.
- Exception then halt: exception at dec_pc=0x30 -> epc=0x30, fetch 0x80; halt with request pending -> handshake completes, no load_instr, imem_req stays 0 until rst_.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bundle between the fetch unit (master) and imem (slave).
// imem_req/imem_addr stay stable from assertion until the cycle imem_ready is high.
interface instr_fetch_if #(
    parameter int BITS = 32
);
    logic            imem_req;
    logic [BITS-1:0] imem_addr;
    logic            imem_ready;
    logic [BITS-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch.sv
// Fetch unit: owns the fetch PC, streams imem words to the decoder, redirects on decoder control flow.
// One word per cycle at zero wait (a taken redirect drops one word); stalls with req/addr held while imem_ready is low.
module instr_fetch #(
    parameter int              BITS       = 32,
    parameter int              JMP_LEFT   = 25,
    parameter int              IMM_LEFT   = 16,
    parameter logic [BITS-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [BITS-1:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic                clk,
    input  logic                rst_,
    instr_fetch_if.master       imem,
    output logic [BITS-1:0]     mem_data,
    output logic                load_instr,
    input  logic                jmp,
    input  logic                jal,
    input  logic                jreg,
    input  logic                breq,
    input  logic                brne,
    input  logic                exception,
    input  logic                halt,
    input  logic                equal,
    input  logic                not_equal,
    input  logic [JMP_LEFT:0]   addr,
    input  logic [IMM_LEFT-1:0] imm,
    input  logic [BITS-1:0]     jreg_data,
    output logic [BITS-1:0]     pc,
    output logic [BITS-1:0]     link_pc,
    output logic [BITS-1:0]     epc
);
    localparam int JHI_W  = BITS - JMP_LEFT - 3;
    localparam int SEXT_W = BITS - IMM_LEFT - 2;

    typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;

    state_t          state, state_nxt;
    logic [BITS-1:0] fetch_pc, dec_pc, pend_pc, target;
    logic            dec_valid, redir_done, discard;
    logic            in_fetch, accept, halt_now, taken, redirect;

    assign in_fetch       = (state == FETCH);
    assign imem.imem_req  = in_fetch;
    assign imem.imem_addr = fetch_pc;
    assign accept         = in_fetch & imem.imem_ready;
    assign mem_data       = imem.imem_rdata;
    assign pc             = fetch_pc;
    assign link_pc        = dec_pc + BITS'(4);

    always_comb begin
        taken  = 1'b1;
        target = link_pc + {{SEXT_W{imm[IMM_LEFT-1]}}, imm, 2'b00};
        if (exception)
            target = EXC_VECTOR;
        else if (jreg)
            target = jreg_data;
        else if (jmp | jal)
            target = {link_pc[BITS-1 -: JHI_W], addr, 2'b00};
        else
            taken = (breq & equal) | (brne & not_equal);
    end

    // redir_done limits each decoded instruction to one redirect: JAL stays in the decoder
    assign halt_now   = in_fetch & dec_valid & halt;
    assign redirect   = in_fetch & dec_valid & ~redir_done & ~halt & taken;
    assign load_instr = accept & ~discard & ~redirect & ~halt_now;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = FETCH;
            FETCH:   if (halt_now & imem.imem_ready) state_nxt = HALTED;
            HALTED:  state_nxt = HALTED;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            fetch_pc   <= RESET_PC;
            dec_pc     <= RESET_PC;
            pend_pc    <= RESET_PC;
            epc        <= '0;
            dec_valid  <= 1'b0;
            redir_done <= 1'b0;
            discard    <= 1'b0;
        end else if (load_instr) begin
            dec_pc     <= fetch_pc;
            dec_valid  <= 1'b1;
            redir_done <= 1'b0;
            fetch_pc   <= fetch_pc + BITS'(4);
        end else if (redirect) begin
            redir_done <= 1'b1;
            if (exception) epc <= dec_pc;
            // an unaccepted request must keep its address, so park the target until it completes
            if (imem.imem_ready) begin
                fetch_pc <= target;
                discard  <= 1'b0;
            end else begin
                pend_pc <= target;
                discard <= 1'b1;
            end
        end else if (accept && discard) begin
            fetch_pc <= pend_pc;
            discard  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized run against an instruction-stream model.
module tb_instr_fetch;
    typedef struct packed {
        logic        jmp, jal, jreg, breq, brne, exception, halt, equal, not_equal;
        logic [25:0] addr;
        logic [15:0] imm;
        logic [31:0] jreg_data;
    } ctl_t;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic [31:0] mem_data, pc, link_pc, epc, jreg_data;
    logic        load_instr;
    logic        jmp, jal, jreg, breq, brne, exception, halt, equal, not_equal;
    logic [25:0] addr;
    logic [15:0] imm;
    ctl_t        ctl;
    int          compared = 0;
    int          mismatched = 0;

    instr_fetch_if #(.BITS(32)) bus ();

    instr_fetch dut (
        .clk(clk), .rst_(rst_), .imem(bus), .mem_data(mem_data), .load_instr(load_instr),
        .jmp(jmp), .jal(jal), .jreg(jreg), .breq(breq), .brne(brne), .exception(exception),
        .halt(halt), .equal(equal), .not_equal(not_equal), .addr(addr), .imm(imm),
        .jreg_data(jreg_data), .pc(pc), .link_pc(link_pc), .epc(epc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hA5C3_0F69;
    endfunction

    // Address of the instruction that must follow one at p carrying decoder controls c.
    function automatic logic [31:0] next_fetch(input logic [31:0] p, input ctl_t c);
        logic [31:0] ret_addr;
        int          off;
        ret_addr = p + 32'd4;
        off      = int'($signed(c.imm)) * 4;
        if (c.exception) return 32'h0000_0080;
        if (c.jreg) return c.jreg_data;
        if (c.jmp || c.jal) return (ret_addr & 32'hF000_0000) | (32'(c.addr) * 32'd4);
        if ((c.breq && c.equal) || (c.brne && c.not_equal)) return ret_addr + 32'(off);
        return ret_addr;
    endfunction

    function automatic ctl_t random_ctl();
        ctl_t c;
        c           = '0;
        c.exception = ($urandom_range(0, 15) == 0);
        c.jreg      = ($urandom_range(0, 9) == 0);
        c.jmp       = ($urandom_range(0, 9) == 0);
        c.jal       = ($urandom_range(0, 9) == 0);
        c.breq      = ($urandom_range(0, 5) == 0);
        c.brne      = ($urandom_range(0, 5) == 0);
        c.equal     = ($urandom_range(0, 1) == 1);
        c.not_equal = ($urandom_range(0, 1) == 1);
        c.addr      = 26'($urandom);
        c.imm       = 16'($urandom);
        c.jreg_data = $urandom & 32'hFFFF_FFFC;
        return c;
    endfunction

    // One clock of stimulus: decoder controls and memory response applied mid-cycle.
    task automatic cyc(input bit rdy);
        @(negedge clk);
        jmp = ctl.jmp; jal = ctl.jal; jreg = ctl.jreg; breq = ctl.breq; brne = ctl.brne;
        exception = ctl.exception; halt = ctl.halt; equal = ctl.equal; not_equal = ctl.not_equal;
        addr = ctl.addr; imm = ctl.imm; jreg_data = ctl.jreg_data;
        bus.imem_ready = rdy;
        bus.imem_rdata = word_of(bus.imem_addr);
        #1;
    endtask

    task automatic do_reset();
        ctl = '0;
        @(negedge clk);
        rst_ = 1'b0;
        bus.imem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_ = 1'b1;
    endtask

    task automatic run_seq(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1);
    endtask

    task automatic test_reset();
        ctl = '0;
        bus.imem_ready = 1'b1;
        bus.imem_rdata = '0;
        @(negedge clk); rst_ = 1'b0; #1;
        compared++; if (bus.imem_req !== 1'b0) begin mismatched++; $display("FAIL rst_req: got %b want 0", bus.imem_req); end
        compared++; if (bus.imem_addr !== 32'h0) begin mismatched++; $display("FAIL rst_addr: got %h want 0", bus.imem_addr); end
        compared++; if (pc !== 32'h0) begin mismatched++; $display("FAIL rst_pc: got %h want 0", pc); end
        compared++; if (load_instr !== 1'b0) begin mismatched++; $display("FAIL rst_load: got %b want 0", load_instr); end
        compared++; if (link_pc !== 32'h4) begin mismatched++; $display("FAIL rst_link: got %h want 4", link_pc); end
        compared++; if (epc !== 32'h0) begin mismatched++; $display("FAIL rst_epc: got %h want 0", epc); end
        @(negedge clk); rst_ = 1'b1; #1;
        compared++; if (bus.imem_req !== 1'b0) begin mismatched++; $display("FAIL idle_req: got %b want 0", bus.imem_req); end
        compared++; if (load_instr !== 1'b0) begin mismatched++; $display("FAIL idle_load: got %b want 0", load_instr); end
        cyc(1'b0);
        compared++; if (bus.imem_req !== 1'b1) begin mismatched++; $display("FAIL first_req: got %b want 1", bus.imem_req); end
        compared++; if (bus.imem_addr !== 32'h0) begin mismatched++; $display("FAIL first_addr: got %h want 0", bus.imem_addr); end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1);
            compared++; if (bus.imem_addr !== 32'(4 * i)) begin mismatched++; $display("FAIL seq_addr[%0d]: got %h want %h", i, bus.imem_addr, 32'(4 * i)); end
            compared++; if (load_instr !== 1'b1) begin mismatched++; $display("FAIL seq_load[%0d]: got %b want 1", i, load_instr); end
            compared++; if (mem_data !== word_of(32'(4 * i))) begin mismatched++; $display("FAIL seq_data[%0d]: got %h want %h", i, mem_data, word_of(32'(4 * i))); end
            compared++; if (link_pc !== ((i == 0) ? 32'd4 : 32'(4 * i))) begin mismatched++; $display("FAIL seq_link[%0d]: got %h", i, link_pc); end
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < 2; w++) begin
                cyc(1'b0);
                compared++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4 * k)) begin mismatched++; $display("FAIL wait_hold[%0d]: req %b addr %h want 1 %h", k, bus.imem_req, bus.imem_addr, 32'(4 * k)); end
                compared++; if (load_instr !== 1'b0) begin mismatched++; $display("FAIL wait_noload[%0d]: got %b want 0", k, load_instr); end
            end
            cyc(1'b1);
            compared++; if (pc !== 32'(4 * k)) begin mismatched++; $display("FAIL wait_pc[%0d]: got %h want %h", k, pc, 32'(4 * k)); end
            compared++; if (load_instr !== 1'b1 || mem_data !== word_of(32'(4 * k))) begin mismatched++; $display("FAIL wait_load[%0d]: load %b data %h", k, load_instr, mem_data); end
        end
    endtask

    task automatic test_beq();
        do_reset();
        run_seq(5);
        ctl.breq = 1'b1; ctl.equal = 1'b1; ctl.imm = 16'hFFFC;
        cyc(1'b1);
        compared++; if (link_pc !== 32'h14) begin mismatched++; $display("FAIL beq_link: got %h want 14", link_pc); end
        compared++; if (load_instr !== 1'b0) begin mismatched++; $display("FAIL beq_drop: got %b want 0", load_instr); end
        cyc(1'b1);
        compared++; if (bus.imem_addr !== 32'h4 || load_instr !== 1'b1) begin mismatched++; $display("FAIL beq_target: addr %h load %b want 4 1", bus.imem_addr, load_instr); end
        ctl = '0;
        cyc(1'b1);
        compared++; if (bus.imem_addr !== 32'h8 || load_instr !== 1'b1) begin mismatched++; $display("FAIL beq_once: addr %h load %b want 8 1", bus.imem_addr, load_instr); end
    endtask

    task automatic test_jal_held();
        do_reset();
        run_seq(9);
        ctl.jal = 1'b1; ctl.jmp = 1'b1; ctl.addr = 26'h40;
        cyc(1'b1);
        compared++; if (link_pc !== 32'h24) begin mismatched++; $display("FAIL jal_link: got %h want 24", link_pc); end
        compared++; if (load_instr !== 1'b0) begin mismatched++; $display("FAIL jal_drop: got %b want 0", load_instr); end
        cyc(1'b1);
        compared++; if (bus.imem_addr !== 32'h100 || load_instr !== 1'b1) begin mismatched++; $display("FAIL jal_target: addr %h load %b want 100 1", bus.imem_addr, load_instr); end
        ctl = '0;
        cyc(1'b1);
        compared++; if (bus.imem_addr !== 32'h104 || load_instr !== 1'b1) begin mismatched++; $display("FAIL jal_once: addr %h load %b want 104 1", bus.imem_addr, load_instr); end
    endtask

    task automatic test_redirect_pending();
        do_reset();
        run_seq(3);
        ctl.jreg = 1'b1; ctl.jreg_data = 32'h200;
        for (int w = 0; w < 2; w++) begin
            cyc(1'b0);
            compared++; if (bus.imem_addr !== 32'hC || load_instr !== 1'b0) begin mismatched++; $display("FAIL jr_hold[%0d]: addr %h load %b want c 0", w, bus.imem_addr, load_instr); end
        end
        cyc(1'b1);
        compared++; if (bus.imem_addr !== 32'hC || load_instr !== 1'b0) begin mismatched++; $display("FAIL jr_drop: addr %h load %b want c 0", bus.imem_addr, load_instr); end
        cyc(1'b1);
        compared++; if (bus.imem_addr !== 32'h200 || load_instr !== 1'b1) begin mismatched++; $display("FAIL jr_target: addr %h load %b want 200 1", bus.imem_addr, load_instr); end
        ctl = '0;
        cyc(1'b1);
        compared++; if (bus.imem_addr !== 32'h204 || load_instr !== 1'b1) begin mismatched++; $display("FAIL jr_next: addr %h load %b want 204 1", bus.imem_addr, load_instr); end
    endtask

    task automatic test_exception_halt();
        do_reset();
        run_seq(13);
        ctl.exception = 1'b1;
        cyc(1'b1);
        compared++; if (load_instr !== 1'b0) begin mismatched++; $display("FAIL exc_drop: got %b want 0", load_instr); end
        cyc(1'b1);
        compared++; if (bus.imem_addr !== 32'h80 || load_instr !== 1'b1) begin mismatched++; $display("FAIL exc_vector: addr %h load %b want 80 1", bus.imem_addr, load_instr); end
        compared++; if (epc !== 32'h30) begin mismatched++; $display("FAIL exc_epc: got %h want 30", epc); end
        ctl = '0; ctl.halt = 1'b1;
        cyc(1'b0);
        compared++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h84 || load_instr !== 1'b0) begin mismatched++; $display("FAIL halt_pend: req %b addr %h load %b", bus.imem_req, bus.imem_addr, load_instr); end
        cyc(1'b1);
        compared++; if (bus.imem_req !== 1'b1 || load_instr !== 1'b0) begin mismatched++; $display("FAIL halt_complete: req %b load %b want 1 0", bus.imem_req, load_instr); end
        ctl = '0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1);
            compared++; if (bus.imem_req !== 1'b0 || load_instr !== 1'b0) begin mismatched++; $display("FAIL halted[%0d]: req %b load %b want 0 0", i, bus.imem_req, load_instr); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_seq(2);
        cyc(1'b0);
        #2 rst_ = 1'b0;
        #1;
        compared++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0) begin mismatched++; $display("FAIL mid_rst: req %b addr %h want 0 0", bus.imem_req, bus.imem_addr); end
        compared++; if (epc !== 32'h0) begin mismatched++; $display("FAIL mid_rst_epc: got %h want 0", epc); end
        bus.imem_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_ = 1'b1; #1;
        compared++; if (load_instr !== 1'b0) begin mismatched++; $display("FAIL mid_late_ready: got %b want 0", load_instr); end
        cyc(1'b1);
        compared++; if (bus.imem_addr !== 32'h0 || load_instr !== 1'b1) begin mismatched++; $display("FAIL mid_restart: addr %h load %b want 0 1", bus.imem_addr, load_instr); end
    endtask

    task automatic test_random();
        logic [31:0] exp_addr, dec_pc_m, exp_epc, prev_addr;
        bit          have_dec, prev_wait, rdy;
        int          loads;
        do_reset();
        exp_addr = 32'h0; dec_pc_m = 32'h0; exp_epc = 32'h0; prev_addr = 32'h0;
        have_dec = 1'b0; prev_wait = 1'b0; loads = 0;
        for (int c = 0; c < 4000; c++) begin
            rdy = ($urandom_range(0, 9) < 6);
            cyc(rdy);
            compared++; if (bus.imem_req !== 1'b1) begin mismatched++; $display("FAIL rnd_req[%0d]: got %b want 1", c, bus.imem_req); end
            if (prev_wait) begin
                compared++; if (bus.imem_addr !== prev_addr) begin mismatched++; $display("FAIL rnd_stable[%0d]: got %h want %h", c, bus.imem_addr, prev_addr); end
            end
            compared++; if (load_instr === 1'b1 && !rdy) begin mismatched++; $display("FAIL rnd_load_no_ready[%0d]: load 1 ready 0", c); end
            if (have_dec) begin
                compared++; if (link_pc !== dec_pc_m + 32'd4) begin mismatched++; $display("FAIL rnd_link[%0d]: got %h want %h", c, link_pc, dec_pc_m + 32'd4); end
            end
            if (load_instr === 1'b1) begin
                loads++;
                compared++; if (bus.imem_addr !== exp_addr) begin mismatched++; $display("FAIL rnd_stream[%0d]: got %h want %h", c, bus.imem_addr, exp_addr); end
                compared++; if (mem_data !== word_of(exp_addr)) begin mismatched++; $display("FAIL rnd_data[%0d]: got %h want %h", c, mem_data, word_of(exp_addr)); end
                compared++; if (epc !== exp_epc) begin mismatched++; $display("FAIL rnd_epc[%0d]: got %h want %h", c, epc, exp_epc); end
                dec_pc_m = exp_addr;
                have_dec = 1'b1;
                ctl      = random_ctl();
                if (ctl.exception) exp_epc = dec_pc_m;
                exp_addr = next_fetch(dec_pc_m, ctl);
            end
            prev_wait = !rdy;
            prev_addr = bus.imem_addr;
        end
        compared++; if (loads < 500) begin mismatched++; $display("FAIL rnd_progress: got %0d loads want >= 500", loads); end
    endtask

    initial begin
        ctl = '0;
        jmp = 0; jal = 0; jreg = 0; breq = 0; brne = 0; exception = 0; halt = 0;
        equal = 0; not_equal = 0; addr = '0; imm = '0; jreg_data = '0;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = '0;
        test_reset();
        test_sequential();
        test_wait_states();
        test_beq();
        test_jal_held();
        test_redirect_pending();
        test_exception_halt();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
